async_fifo_wr_ctrl: RTL

Write-domain pointer/flag controller for the dual-clock FIFO. It is the counterpart of the read-side controller.
- Owns the binary write pointer and produces the memory write address and gated write enable.
- Publishes a registered Gray write pointer for synchronization into the read domain.
- Derives full, almost-full, fill level and a sticky overflow flag from the read Gray pointer, which has already been synchronized into the write domain.

---
 rtl/async_fifo_wr_ctrl.sv | 84 ++++++++
 1 files changed

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side pointer/flag controller for the dual-clock FIFO.
// Define ASYNC_FIFO_WR_LEVEL_EN to build the fill-level / almost-full logic.
module async_fifo_wr_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_MARGIN  = 1
) (
  input  logic                  W_CLK,
  input  logic                  W_RST,
  input  logic                  wr_inc,
  input  logic                  wr_ovf_clr,
  input  logic [ADDR_WIDTH:0]   gray_rd_ptr_sync,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_en,
  output logic [ADDR_WIDTH:0]   gray_wr_ptr,
  output logic                  wr_full,
  output logic                  wr_almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  wr_overflow
);
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (ADDR_WIDTH < 2 || DATA_WIDTH < 1 || AF_MARGIN < 0 || AF_MARGIN >= DEPTH) begin : g_bad_param
    $error("async_fifo_wr_ctrl: illegal parameter set");
  end

  logic [PW-1:0] r_bin;
  logic [PW-1:0] r_gray;
  logic          r_ovf;
  logic [PW-1:0] w_bin_next;
  logic          w_full;
  logic          w_en;

  // Full: top two Gray bits inverted, the rest equal (writer one lap ahead).
  assign w_full     = (r_gray[PW-1:PW-2] == ~gray_rd_ptr_sync[PW-1:PW-2]) &&
                      (r_gray[PW-3:0]    ==  gray_rd_ptr_sync[PW-3:0]);
  assign w_en       = wr_inc & ~w_full;
  assign w_bin_next = r_bin + 1'b1;

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      r_bin  <= '0;
      r_gray <= '0;
    end else if (w_en) begin
      r_bin  <= w_bin_next;
      r_gray <= w_bin_next ^ (w_bin_next >> 1);
    end
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST)                r_ovf <= 1'b0;
    else if (wr_inc && w_full) r_ovf <= 1'b1;
    else if (wr_ovf_clr)       r_ovf <= 1'b0;
  end

`ifdef ASYNC_FIFO_WR_LEVEL_EN
  localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
  localparam logic [PW-1:0] MARGIN_P = PW'(AF_MARGIN);
  logic [PW-1:0] w_rd_bin;
  logic [PW-1:0] w_level;

  always_comb begin
    w_rd_bin[PW-1] = gray_rd_ptr_sync[PW-1];
    for (int i = PW - 2; i >= 0; i--)
      w_rd_bin[i] = w_rd_bin[i+1] ^ gray_rd_ptr_sync[i];
  end

  // Read pointer lags, so this level errs high.
  assign w_level        = r_bin - w_rd_bin;
  assign wr_level       = w_level;
  assign wr_almost_full = (DEPTH_P - w_level) <= MARGIN_P;
`else
  assign wr_level       = '0;
  assign wr_almost_full = w_full;
`endif

  assign wr_addr     = r_bin[ADDR_WIDTH-1:0];
  assign wr_en       = w_en;
  assign gray_wr_ptr = r_gray;
  assign wr_full     = w_full;
  assign wr_overflow = r_ovf;
endmodule
